uart_word_rx: RTL
=================

# uart_word_rx

Serial-to-word receiver for the board UART link, the inverse of the word transmit path. It deserialises 8N1 frames from `rx_pin_in` and reassembles `len` consecutive bytes, LSB byte first, into a 64-bit word. It pulses `word_valid` with the assembled word and reports framing errors and inter-byte gap timeouts. It runs in the 50 MHz UART clock domain (`clk_trx`) and is used for word loads from the host and for loopback checks of the transmitter.

## Interface
- `CLK_DIV`, 434: clocks per bit (50 MHz / 115200); must be ≥ 4 and even.
- `GAP_CYCLES`, 20 × `CLK_DIV`: idle clocks allowed between bytes of one word before the partial word is dropped.

- `clk`  in  1  UART clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_pin_in`  in  1  serial line, idle high; asynchronous to `clk`.
- `len`  in  4  bytes per word; values 1..8 are legal, 0 and values above 8 are treated as 8. Latched when the first byte of a word completes.
- `byte_data`  out  8  last received byte.
- `byte_valid`  out  1  one-cycle pulse per good byte.
- `word_data`  out  64  assembled word; byte k is in [8k+7:8k]; unfilled upper bytes are 0.
- `word_len`  out  4  latched length of the word in `word_data`.
- `word_valid`  out  1  one-cycle pulse.
- `frame_err`  out  1  one-cycle pulse; stop bit was sampled low.
- `timeout_err`  out  1  one-cycle pulse; a partial word was discarded.

## Operation
- `rx_pin_in` passes through a 2-FF synchroniser (reset value 1). All detection uses the synchronised signal `rxs`.
- Bit FSM:
  - IDLE: a 1→0 edge on `rxs` moves to START and clears the baud counter.
  - START: at count `CLK_DIV`/2−1, sample `rxs`. Low moves to DATA. High is a glitch and returns to IDLE with no error.
  - DATA: sample every `CLK_DIV` clocks; 8 bits, LSB first, shifted into a byte register. After bit 7, move to STOP.
  - STOP: sample `CLK_DIV` clocks after bit 7. High pulses `byte_valid` and returns to IDLE. Low pulses `frame_err` and moves to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then return to IDLE. This prevents a break condition from producing repeated frames.
- Assembler:
  - Byte index `idx` runs 0..L−1, where L is the latched length.
  - On `byte_valid`: when `idx`=0, latch L from `len`; write the byte to lane `idx`.
  - When `idx`=L−1: on the next cycle, pulse `word_valid` with the word, set `word_len`=L, reset `idx` to 0, and clear the shadow word.
  - `word_data` holds its value until the next word completes.
- Gap counter: runs while `idx`≠0 and clears on each `byte_valid`. On reaching `GAP_CYCLES`: pulse `timeout_err`, reset `idx`, clear the shadow word.
- `frame_err` while `idx`≠0 also aborts the partial word. No extra `timeout_err` is raised.
- A change on `len` mid-word is ignored until the next word.
- Reset mid-frame or mid-word: everything aborts immediately and no pulse is emitted after release.
- Reset values: `byte_data`, `word_data`, `word_len` are 0; all pulses are 0; FSM is in IDLE; `idx` is 0.

## Timing
- Let t0 be the cycle in which `rxs` is first seen low. Start sample at t0+`CLK_DIV`/2. Data bit i is sampled at t0+`CLK_DIV`/2+(i+1)·`CLK_DIV`. Stop bit is sampled at t0+`CLK_DIV`/2+9·`CLK_DIV`.
- `byte_valid` and `frame_err` are registered and assert the cycle after the stop sample.
- `word_valid` asserts exactly 1 cycle after the `byte_valid` of the last byte.
- A new start edge is accepted in the cycle IDLE is re-entered, so back-to-back frames with a single stop bit are received without loss.
- A timeout and a `byte_valid` in the same cycle: the byte wins. The counter clears and no error is raised.
- The word register is written only on completion. A downstream consumer samples it on `word_valid` with no handshake and no backpressure; a missed pulse loses the word.

## Structure
- `uart_pkg` contains:
  - the `rx_state_t` enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - default `CLK_DIV`;
  - the maximum bytes per word (8);
  - the lane-index width.
- Sub-module `uart_rx_byte`: synchroniser, bit FSM and baud counter. It outputs `byte_data`, `byte_valid` and `frame_err`.
- The top level holds the word assembler and gap counter.

## Test plan
- `CLK_DIV`=16, `len`=8, bytes 0x11,0x22,…,0x88 sent back to back → single `word_valid` with `word_data`=0x8877665544332211, `word_len`=8; `byte_valid` 8 times, each 160 clocks apart.
- `len`=3, bytes 0xAA,0xBB,0xCC → `word_data`=0x0000000000CCBBAA, `word_len`=3. Change `len` to 5 after byte 1 → word still completes at 3 bytes.
- Stop bit driven low on byte 2 of a 4-byte word → `frame_err` pulse, no `word_valid`. Line held low 50 bit times → exactly one `frame_err`. The next 4 good bytes → correct word.
- Low glitch of 4 clocks on an idle line → no `byte_valid`, no `frame_err`, FSM back in IDLE.
- `GAP_CYCLES`=400, two bytes of a 4-byte word then silence → `timeout_err` 400 clocks after the second `byte_valid`. The next 4 bytes form a fresh word.
- `rst_n` asserted mid-bit of byte 5 → all outputs 0 immediately, no pulses after release. The next full word is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART word receive path.
package uart_pkg;

  // Bit-level receiver states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  // 50 MHz / 115200 baud.
  localparam int CLK_DIV_DEFAULT = 434;

  // Bytes per assembled word and the width of a byte-lane index.
  localparam int MAX_BYTES = 8;
  localparam int LANE_W    = 3;

  // Map the requested length onto 1..8; 0 and anything above 8 mean a full word.
  function automatic logic [3:0] norm_len(input logic [3:0] len_raw);
    logic [3:0] res;
    if ((len_raw == 4'd0) || (len_raw > 4'd8)) begin
      res = 4'd8;
    end else begin
      res = len_raw;
    end
    return res;
  endfunction

  // Return the word with byte lane 'lane' replaced by 'b'.
  function automatic logic [8*MAX_BYTES-1:0] put_lane(input logic [8*MAX_BYTES-1:0] w,
                                                      input logic [LANE_W-1:0]      lane,
                                                      input logic [7:0]             b);
    logic [8*MAX_BYTES-1:0] res;
    res = w;
    res[{lane, 3'b000} +: 8] = b;
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit FSM and baud counter.
// Emits a registered byte_valid pulse for a good stop bit and a frame_err
// pulse for a low stop bit, after which it waits for the line to go idle.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

  logic             sync1_q;
  logic             rxs_q;
  logic             rxs_prev_q;
  logic             fall_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // Two-flop synchroniser (idle-high reset) plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_pin_in;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign fall_s = rxs_prev_q & ~rxs_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic: start-bit qualification, mid-bit sampling, stop check.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          if (!rxs_q) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs_q) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line returns high so a break yields one error only.
        cnt_d = '0;
        if (rxs_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_HIGH;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_word_rx.sv
// Serial-to-word receiver: collects 1..8 UART bytes (LSB byte first) into a
// 64-bit word, with an inter-byte gap timeout and framing-error abort.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int GAP_CYCLES = 20 * CLK_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin_in,
  input  logic [3:0]  len,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [63:0] word_data,
  output logic [3:0]  word_len,
  output logic        word_valid,
  output logic        frame_err,
  output logic        timeout_err
);

  localparam int WORD_W = 8 * MAX_BYTES;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [LANE_W-1:0] idx_q, idx_d;
  logic [3:0]        len_lat_q, len_lat_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic [3:0]        word_len_q, word_len_d;
  logic              word_valid_q, word_valid_d;
  logic              timeout_q, timeout_d;
  logic [3:0]        len_cur_s;
  logic [WORD_W-1:0] merged_s;

  uart_rx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_rx_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin_in  (rx_pin_in),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  // Assembler and gap-counter state plus registered word outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      len_lat_q    <= 4'd0;
      shadow_q     <= '0;
      gap_q        <= '0;
      word_data_q  <= '0;
      word_len_q   <= 4'd0;
      word_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      len_lat_q    <= len_lat_d;
      shadow_q     <= shadow_d;
      gap_q        <= gap_d;
      word_data_q  <= word_data_d;
      word_len_q   <= word_len_d;
      word_valid_q <= word_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  // Byte placement, word completion, and abort on timeout or framing error.
  always_comb begin
    idx_d        = idx_q;
    len_lat_d    = len_lat_q;
    shadow_d     = shadow_q;
    gap_d        = gap_q;
    word_data_d  = word_data_q;
    word_len_d   = word_len_q;
    word_valid_d = 1'b0;
    timeout_d    = 1'b0;
    // The length is sampled only by the first byte of a word.
    len_cur_s    = (idx_q == '0) ? norm_len(len) : len_lat_q;
    merged_s     = put_lane(shadow_q, idx_q, byte_data);

    if (byte_valid) begin
      // A byte arriving in the timeout cycle wins: no error, gap restarts.
      len_lat_d = len_cur_s;
      if ({1'b0, idx_q} == (len_cur_s - 4'd1)) begin
        word_data_d  = merged_s;
        word_len_d   = len_cur_s;
        word_valid_d = 1'b1;
        idx_d        = '0;
        shadow_d     = '0;
        gap_d        = '0;
      end else begin
        shadow_d = merged_s;
        idx_d    = idx_q + LANE_W'(1);
        gap_d    = GAP_W'(1);
      end
    end else if (frame_err) begin
      // A bad frame discards any partial word without a timeout report.
      idx_d    = '0;
      shadow_d = '0;
      gap_d    = '0;
    end else if (idx_q != '0) begin
      if (gap_q == GAP_LAST) begin
        timeout_d = 1'b1;
        idx_d     = '0;
        shadow_d  = '0;
        gap_d     = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = '0;
    end
  end

  assign word_data   = word_data_q;
  assign word_len    = word_len_q;
  assign word_valid  = word_valid_q;
  assign timeout_err = timeout_q;

endmodule
